// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection sequencer: state and
// direction encodings, timer width, lamp bundle decode and the
// round-robin arbiter used at the end of each all-red clearance.
package traffic_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_NS  = 2'd0,
    DIR_EW  = 2'd1,
    DIR_PED = 2'd2
  } dir_t;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  // Moore lamp decode: a head is red unless it owns the green/yellow state.
  function automatic lamps_t decode_lamps(input state_t st);
    lamps_t l;
    l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
          ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
    case (st)
      NS_GREEN:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
      NS_YELLOW: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
      EW_GREEN:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
      EW_YELLOW: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
      PED_WALK:  l.walk = 1'b1;
      default:   l.walk = 1'b0;
    endcase
    return l;
  endfunction

  // First pending direction after the last grant (NS -> EW -> PED -> NS);
  // with nothing pending the main road (NS) is chosen. pend is indexed by dir_t.
  function automatic dir_t rr_pick(input dir_t last, input logic [2:0] pend);
    dir_t pick;
    pick = DIR_NS;
    case (last)
      DIR_NS: begin
        if (pend[1])      pick = DIR_EW;
        else if (pend[2]) pick = DIR_PED;
        else              pick = DIR_NS;
      end
      DIR_EW: begin
        if (pend[2])      pick = DIR_PED;
        else if (pend[0]) pick = DIR_NS;
        else if (pend[1]) pick = DIR_EW;
        else              pick = DIR_NS;
      end
      default: begin
        if (pend[0])      pick = DIR_NS;
        else if (pend[1]) pick = DIR_EW;
        else if (pend[2]) pick = DIR_PED;
        else              pick = DIR_NS;
      end
    endcase
    return pick;
  endfunction

  // Service state that a grant to the given direction leads into.
  function automatic state_t green_of(input dir_t d);
    state_t st;
    case (d)
      DIR_NS:  st = NS_GREEN;
      DIR_EW:  st = EW_GREEN;
      DIR_PED: st = PED_WALK;
      default: st = NS_GREEN;
    endcase
    return st;
  endfunction

  // True unless the state is the green of the direction opposite to dir.
  function automatic logic toward_dir(input state_t st, input logic dir);
    logic t;
    case (st)
      NS_GREEN: t = (dir == 1'b0);
      EW_GREEN: t = (dir == 1'b1);
      default:  t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts enabled cycles since the last state change,
// saturates at all-ones and flags when the count equals a target.
module phase_timer
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  input  logic [TIMER_W-1:0] target,
  output logic [TIMER_W-1:0] count,
  output logic               at_target
);

  localparam logic [TIMER_W-1:0] CNT_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] CNT_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] CNT_MAX  = {TIMER_W{1'b1}};

  logic [TIMER_W-1:0] count_r;

  // Counter register: clear wins, otherwise count up while enabled and not saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign count     = count_r;
  assign at_target = (count_r == target);

endmodule

// File: rtl/intersection_sequencer.sv
// Four-way intersection sequencer: phase FSM, demand latching,
// round-robin arbitration, emergency pre-emption and lamp decode.
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int RED_CLR   = 2,
  parameter int YELLOW    = 6,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int WALK      = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  input  logic       emerg,
  input  logic       emerg_dir,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_wait,
  output logic       emerg_active,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] RED_CLR_M1   = TIMER_W'(RED_CLR - 1);
  localparam logic [TIMER_W-1:0] YELLOW_M1    = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] WALK_M1      = TIMER_W'(WALK - 1);
  localparam logic [TIMER_W-1:0] GREEN_MIN_M1 = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GREEN_MAX_M1 = TIMER_W'(GREEN_MAX - 1);

  state_t             state_r, state_s;
  dir_t               last_r, last_s, grant_s;
  logic               pend_ns_r, pend_ew_r, pend_ped_r;
  logic               abort_s;
  logic [TIMER_W-1:0] count_s, target_s;
  logic               at_target_s, timer_clr_s;
  logic               min_done_s, max_done_s, ns_other_s, ew_other_s;
  logic               enter_ns_s, enter_ew_s, enter_ped_s;
  lamps_t             lamps_r;
  logic               emerg_active_r;

  assign min_done_s  = (count_s >= GREEN_MIN_M1);
  assign max_done_s  = (count_s >= GREEN_MAX_M1);
  assign ns_other_s  = pend_ew_r | pend_ped_r;
  assign ew_other_s  = pend_ns_r | pend_ped_r;
  assign grant_s     = emerg ? (emerg_dir ? DIR_EW : DIR_NS)
                             : rr_pick(last_r, {pend_ped_r, pend_ew_r, pend_ns_r});
  assign timer_clr_s = (state_s != state_r);
  assign enter_ns_s  = (state_s == NS_GREEN) && (state_r != NS_GREEN);
  assign enter_ew_s  = (state_s == EW_GREEN) && (state_r != EW_GREEN);
  assign enter_ped_s = (state_s == PED_WALK) && (state_r != PED_WALK);

  // Duration target for the fixed-length states; greens use >= compares instead.
  always_comb begin
    target_s = {TIMER_W{1'b0}};
    case (state_r)
      ALL_RED:              target_s = RED_CLR_M1;
      NS_YELLOW, EW_YELLOW: target_s = YELLOW_M1;
      PED_WALK:             target_s = WALK_M1;
      default:              target_s = {TIMER_W{1'b0}};
    endcase
  end

  phase_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (enable),
    .clr       (timer_clr_s),
    .target    (target_s),
    .count     (count_s),
    .at_target (at_target_s)
  );

  // Next-state logic; emergency overrides greens and walk but never shortens clearance.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    abort_s = 1'b0;
    if (enable) begin
      case (state_r)
        ALL_RED: begin
          if (at_target_s) begin
            state_s = green_of(grant_s);
            last_s  = grant_s;
          end else begin
            state_s = ALL_RED;
          end
        end
        NS_GREEN: begin
          if (emerg) begin
            state_s = emerg_dir ? NS_YELLOW : NS_GREEN;
          end else if (ns_other_s && (max_done_s || (min_done_s && !car_ns))) begin
            state_s = NS_YELLOW;
          end else begin
            state_s = NS_GREEN;
          end
        end
        EW_GREEN: begin
          if (emerg) begin
            state_s = emerg_dir ? EW_GREEN : EW_YELLOW;
          end else if (ew_other_s && (max_done_s || (min_done_s && !car_ew))) begin
            state_s = EW_YELLOW;
          end else begin
            state_s = EW_GREEN;
          end
        end
        NS_YELLOW, EW_YELLOW: begin
          state_s = at_target_s ? ALL_RED : state_r;
        end
        PED_WALK: begin
          if (emerg) begin
            state_s = ALL_RED;
            abort_s = 1'b1;
          end else if (at_target_s) begin
            state_s = ALL_RED;
          end else begin
            state_s = PED_WALK;
          end
        end
        default: state_s = ALL_RED;
      endcase
    end else begin
      state_s = state_r;
      last_s  = last_r;
      abort_s = 1'b0;
    end
  end

  // State and round-robin pointer registers; pointer starts at PED so NS is served first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ALL_RED;
      last_r  <= DIR_PED;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Demand latches: set by their input, cleared (with priority) when service begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_ns_r  <= 1'b0;
      pend_ew_r  <= 1'b0;
      pend_ped_r <= 1'b0;
    end else begin
      pend_ns_r  <= enter_ns_s  ? 1'b0 : (pend_ns_r | car_ns);
      pend_ew_r  <= enter_ew_s  ? 1'b0 : (pend_ew_r | car_ew);
      pend_ped_r <= enter_ped_s ? 1'b0 : (pend_ped_r | ped_req | abort_s);
    end
  end

  // Registered lamp and status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lamps_r        <= decode_lamps(ALL_RED);
      emerg_active_r <= 1'b0;
    end else begin
      lamps_r        <= decode_lamps(state_s);
      emerg_active_r <= emerg & toward_dir(state_s, emerg_dir);
    end
  end

  assign ns_red       = lamps_r.ns_red;
  assign ns_yellow    = lamps_r.ns_yellow;
  assign ns_green     = lamps_r.ns_green;
  assign ew_red       = lamps_r.ew_red;
  assign ew_yellow    = lamps_r.ew_yellow;
  assign ew_green     = lamps_r.ew_green;
  assign walk         = lamps_r.walk;
  assign ped_wait     = pend_ped_r;
  assign emerg_active = emerg_active_r;
  assign phase        = state_r;

endmodule
